auction_stream: RTL and testbench
=================================

# auction_stream

Sequential sealed-bid auction engine: accepts one bid per cycle over a valid/ready stream from `2**N` bidders in index order, keeps a running maximum, and returns the winner index and winning bid through an output handshake. It is the streaming successor of the combinational tournament auction. It trades the `2**N`-wide bid bus for a single `W`-bit port and adds optional second-price (Vickrey) settlement. It sits between the bid-collection front end and the settlement/BMR output stage.

## Interface
- `N`, default 2: log2 of bidder count; bidders 0..`2**N-1`.
- `W`, default 2: bid width, unsigned.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  pulse that begins an auction; honoured only in IDLE.
- `busy`  out  1  high in COLLECT and DONE.
- `bid_valid`  in  1  bid present on `bid`.
- `bid_ready`  out  1  high only in COLLECT.
- `bid`  in  W  bid of the bidder whose index equals the internal counter.
- `res_valid`  out  1  result available; high only in DONE.
- `res_ready`  in  1  consumer accepts result.
- `winner`  out  N  index of the highest bidder.
- `winning_bid`  out  W  highest bid.
- `price`  out  W  settlement price (see Configuration).

## Operation
- FSM states: IDLE, COLLECT, DONE. Encoding comes from the package.
- IDLE: `start`=1 moves to COLLECT. On the same edge it clears `cnt`, `best`, `second` and `best_id` to 0. `start` is ignored in COLLECT and DONE.
- COLLECT: each cycle with `bid_valid && bid_ready` is one accepted bid for bidder `cnt`.
  - If `bid > best`: `second <= best`, `best <= bid`, `best_id <= cnt`.
  - Else if `bid > second`: `second <= bid`.
  - Then `cnt <= cnt+1`.
- Comparisons are strict unsigned. On a tie the lower index wins, and a tying bid raises `second` to the top value.
- The accepted bid with `cnt == 2**N-1` moves the FSM to DONE. `cnt` is N+1 bits wide internally, or uses a last flag, so that wrap-around is never used as the terminator.
- DONE: `res_valid`=1. `winner`, `winning_bid` and `price` are driven from registers and held stable until `res_ready`=1. On that edge the FSM returns to IDLE.
- Outputs keep their last values in IDLE. They update only during COLLECT.
- Widths: `best` and `second` are W bits; `best_id` is N bits. No arithmetic is performed beyond comparison.

## Timing
- Reset values: `busy`=0, `bid_ready`=0, `res_valid`=0, `winner`=0, `winning_bid`=0, `price`=0. The state returns to IDLE.
- `rst` mid-auction, in any state, has priority over every other input. Partial bids are discarded.
- `start` accepted at edge t: `bid_ready`=1 from cycle t+1.
- Minimum auction duration is `2**N` bid cycles. `bid_valid` gaps stall without changing state.
- `res_valid` rises in the cycle after the last bid handshake. The result is combinationally visible with `res_valid`.
- With `res_ready` held at 1, DONE lasts one cycle. IDLE follows, and the next `start` can be accepted in that IDLE cycle.
- `start` asserted during DONE is not queued.

## Configuration
- `AUCTION_SECOND_PRICE_EN` defined:
  - The `second` register and its update logic are compiled in.
  - `price` equals the second-highest accepted bid, counting duplicates.
  - With `N`=0 (single bidder), `price` = 0.
- Macro undefined:
  - The `second` register is absent.
  - `price` is tied to `winning_bid`, giving first-price settlement.

## Structure
- Package `auction_pkg` holds the FSM state enum (IDLE, COLLECT, DONE) and the `2**N` bidder-count helper function.
- Sub-module `auction_update` holds the combinational compare/update step.
  - Inputs: `bid`, `cnt`, `best`, `second`, `best_id`.
  - Outputs: next `best`, `second`, `best_id`.
  - It is instantiated once in `auction_stream`; registers and the FSM live in the top.

## Test plan
All cases use N=2, W=4.
- Bids 2,7,4,1, back-to-back, with `res_ready`=1 -> `winner`=1, `winning_bid`=7. `price`=4 with the macro, 7 without. `res_valid` rises one cycle after the 4th bid.
- Bids 3,9,5,9 -> `winner`=1 (lower index wins the tie), `winning_bid`=9, `price`=9 with the macro.
- All bids 0 -> `winner`=0, `winning_bid`=0, `price`=0. Bids 15,15,15,15 -> `winner`=0, `price`=15.
- `bid_valid` toggling 1,0,0,1,… and `res_ready` held low 5 cycles in DONE -> identical result to the gap-free run. Outputs stay stable while `res_valid`=1. `start` pulses during COLLECT and DONE are ignored.
- `rst` after 2 accepted bids (9,3) -> next cycle all outputs 0 and IDLE. A new auction with bids 1,2,3,4 -> `winner`=3, `winning_bid`=4, `price`=3 (macro).
- Two auctions back-to-back, with `start` in the first IDLE cycle after the result handshake -> the second result is unaffected by the first auction's register values.

Source files
------------

// File: rtl/auction_pkg.sv
// Shared types and helpers for the streaming sealed-bid auction engine.
package auction_pkg;

    // FSM state encoding for auction_stream.
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCollect = 2'd1,
        StDone    = 2'd2
    } auction_state_e;

    // Number of bidders for a given log2 bidder count.
    function automatic int unsigned num_bidders(input int unsigned n);
        return 32'd1 << n;
    endfunction

endpackage

// File: rtl/auction_update.sv
// Combinational compare/update step of the running auction maximum.
// Optional macro: AUCTION_SECOND_PRICE_EN adds second-highest tracking.
module auction_update
    import auction_pkg::*;
#(
    parameter int unsigned N = 2,
    parameter int unsigned W = 2
) (
    input  logic [W-1:0] bid,
    input  logic [N-1:0] cnt,
    input  logic [W-1:0] best,
`ifdef AUCTION_SECOND_PRICE_EN
    input  logic [W-1:0] second,
    output logic [W-1:0] second_next,
`endif
    input  logic [N-1:0] best_id,
    output logic [W-1:0] best_next,
    output logic [N-1:0] best_id_next
);

    // Strict compare: a tying bid never displaces the lower-index leader.
    always_comb begin
        best_next    = best;
        best_id_next = best_id;
`ifdef AUCTION_SECOND_PRICE_EN
        second_next  = second;
`endif
        if (bid > best) begin
            best_next    = bid;
            best_id_next = cnt;
`ifdef AUCTION_SECOND_PRICE_EN
            second_next  = best;
        end else if (bid > second) begin
            // A tie with the leader lands here and lifts second to the top value.
            second_next  = bid;
`endif
        end
    end

endmodule

// File: rtl/auction_stream.sv
// Sequential sealed-bid auction: one bid per cycle from 2**N bidders in
// index order, result returned over a valid/ready handshake.
// Optional macro: AUCTION_SECOND_PRICE_EN selects second-price settlement;
// without it the price equals the winning bid.
module auction_stream
    import auction_pkg::*;
#(
    parameter int unsigned N = 2,
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         busy,
    input  logic         bid_valid,
    output logic         bid_ready,
    input  logic [W-1:0] bid,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] winner,
    output logic [W-1:0] winning_bid,
    output logic [W-1:0] price
);

    // One extra counter bit so the terminator never relies on wrap-around.
    localparam int unsigned CntW = N + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(num_bidders(N) - 1);

    auction_state_e state_q;
    logic [CntW-1:0] cnt_q;
    logic [W-1:0]    best_q;
    logic [N-1:0]    best_id_q;
    logic [W-1:0]    best_next;
    logic [N-1:0]    best_id_next;
    logic            busy_q;
    logic            bid_ready_q;
    logic            res_valid_q;

`ifdef AUCTION_SECOND_PRICE_EN
    logic [W-1:0]    second_q;
    logic [W-1:0]    second_next;
`endif

    auction_update #(
        .N (N),
        .W (W)
    ) u_update (
        .bid          (bid),
        .cnt          (cnt_q[N-1:0]),
        .best         (best_q),
`ifdef AUCTION_SECOND_PRICE_EN
        .second       (second_q),
        .second_next  (second_next),
`endif
        .best_id      (best_id_q),
        .best_next    (best_next),
        .best_id_next (best_id_next)
    );

    // FSM, running maximum and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            best_q      <= '0;
            best_id_q   <= '0;
`ifdef AUCTION_SECOND_PRICE_EN
            second_q    <= '0;
`endif
            busy_q      <= 1'b0;
            bid_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q     <= StCollect;
                        cnt_q       <= '0;
                        best_q      <= '0;
                        best_id_q   <= '0;
`ifdef AUCTION_SECOND_PRICE_EN
                        second_q    <= '0;
`endif
                        busy_q      <= 1'b1;
                        bid_ready_q <= 1'b1;
                    end
                end
                StCollect: begin
                    if (bid_valid) begin
                        best_q    <= best_next;
                        best_id_q <= best_id_next;
`ifdef AUCTION_SECOND_PRICE_EN
                        second_q  <= second_next;
`endif
                        cnt_q     <= cnt_q + CntW'(1);
                        if (cnt_q == LastCnt) begin
                            state_q     <= StDone;
                            bid_ready_q <= 1'b0;
                            res_valid_q <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    if (res_ready) begin
                        state_q     <= StIdle;
                        busy_q      <= 1'b0;
                        res_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    busy_q      <= 1'b0;
                    bid_ready_q <= 1'b0;
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign bid_ready   = bid_ready_q;
    assign res_valid   = res_valid_q;
    assign winner      = best_id_q;
    assign winning_bid = best_q;
`ifdef AUCTION_SECOND_PRICE_EN
    assign price       = second_q;
`else
    assign price       = best_q;
`endif

endmodule

// File: tb/tb_auction_stream.sv
// Scoreboard bench for auction_stream (N=2, W=4). Expected results are
// queued by the stimulus process and checked by an independent monitor.
module tb_auction_stream;

    logic       clk;
    logic       rst;
    logic       start;
    logic       busy;
    logic       bid_valid;
    logic       bid_ready;
    logic [3:0] bid;
    logic       res_valid;
    logic       res_ready;
    logic [1:0] winner;
    logic [3:0] winning_bid;
    logic [3:0] price;

    typedef struct packed {
        logic [1:0] win;
        logic [3:0] wbid;
        logic [3:0] prc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    auction_stream #(
        .N (2),
        .W (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .bid_valid   (bid_valid),
        .bid_ready   (bid_ready),
        .bid         (bid),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .winner      (winner),
        .winning_bid (winning_bid),
        .price       (price)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the expected result; first-price settlement pays the winning bid.
    task automatic push_exp(input logic [1:0] w, input logic [3:0] wb, input logic [3:0] p2);
        exp_t e;
        e.win  = w;
        e.wbid = wb;
`ifdef AUCTION_SECOND_PRICE_EN
        e.prc  = p2;
`else
        e.prc  = wb;
`endif
        exp_q.push_back(e);
    endtask

    // bids packed {b3,b2,b1,b0}; gaps inserts two idle cycles before bids 1..3;
    // hold keeps res_ready low that many DONE cycles.
    task automatic run_auction(input logic [15:0] bids, input logic [1:0] w,
                               input logic [3:0] wb, input logic [3:0] p2,
                               input bit gaps, input int hold);
        push_exp(w, wb, p2);
        res_ready = (hold == 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("bid_ready_after_start", int'(bid_ready), 1);
        for (int i = 0; i < 4; i++) begin
            if (gaps && i > 0) begin
                bid_valid = 1'b0;
                start = 1'b1;  // ignored in COLLECT
                tick();
                start = 1'b0;
                tick();
            end
            if (i == 3) check("res_valid_before_last", int'(res_valid), 0);
            bid_valid = 1'b1;
            bid = bids[i*4 +: 4];
            tick();
        end
        bid_valid = 1'b0;
        check("res_valid_after_last", int'(res_valid), 1);
        check("bid_ready_in_done", int'(bid_ready), 0);
        for (int k = 0; k < hold; k++) begin
            start = (k == 2);  // not queued
            tick();
        end
        start = 1'b0;
        res_ready = 1'b1;
        tick();
        check("busy_after_handshake", int'(busy), 0);
        check("res_valid_after_handshake", int'(res_valid), 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", int'(busy), 0);
        check("rst_bid_ready", int'(bid_ready), 0);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_winner", int'(winner), 0);
        check("rst_winning_bid", int'(winning_bid), 0);
        check("rst_price", int'(price), 0);
    endtask

    // Monitor: compare whenever a result is presented; pop on handshake.
    always @(negedge clk) begin
        if (!rst && res_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_result: got winner %0d bid %0d expected none",
                         winner, winning_bid);
            end else begin
                check("winner", int'(winner), int'(exp_q[0].win));
                check("winning_bid", int'(winning_bid), int'(exp_q[0].wbid));
                check("price", int'(price), int'(exp_q[0].prc));
                if (res_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        bid_valid = 1'b0;
        bid       = '0;
        res_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_reset_outputs();

        // Back-to-back auctions, start in the first IDLE cycle each time.
        run_auction({4'd1, 4'd4, 4'd7, 4'd2}, 2'd1, 4'd7, 4'd4, 1'b0, 0);
        run_auction({4'd9, 4'd5, 4'd9, 4'd3}, 2'd1, 4'd9, 4'd9, 1'b0, 0);
        run_auction({4'd0, 4'd0, 4'd0, 4'd0}, 2'd0, 4'd0, 4'd0, 1'b0, 0);
        run_auction({4'd15, 4'd15, 4'd15, 4'd15}, 2'd0, 4'd15, 4'd15, 1'b0, 0);

        // Gapped bids and stalled result give the same answer.
        run_auction({4'd1, 4'd4, 4'd7, 4'd2}, 2'd1, 4'd7, 4'd4, 1'b1, 5);

        // Mid-auction reset discards partial bids.
        start = 1'b1;
        tick();
        start = 1'b0;
        bid_valid = 1'b1;
        bid = 4'd9;
        tick();
        bid = 4'd3;
        tick();
        bid_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs();
        tick();
        check("idle_after_reset_busy", int'(busy), 0);

        run_auction({4'd4, 4'd3, 4'd2, 4'd1}, 2'd3, 4'd4, 4'd3, 1'b0, 0);

        tick();
        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
